// File: rtl/apb_pkg.sv
// Shared APB definitions: requester FSM states, default bus widths and the
// peripheral's legal address limit used by the slave model and the benches.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int APB_ADDR_LIMIT = 1024;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags the edge on which the limit is reached.
// A TIMEOUT of 0 keeps the counter running but never signals expiry.
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = (TIMEOUT < 1) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted on the wait edge that would bring the count up to TIMEOUT.
    assign expired = (TIMEOUT > 0) && count_en && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: turns valid/ready commands into SETUP/ACCESS transfers and
// returns a one-cycle response strobe, aborting on a wait-state timeout.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              pselx,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pslverr
);

    apb_state_e        state_q, state_d;
    logic              pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              timer_clear;
    logic              timer_en;
    logic              timer_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk     (pclk),
        .presetn  (presetn),
        .clear    (timer_clear),
        .count_en (timer_en),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        pselx_d       = pselx_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = 1'b0;
        rsp_timeout_d = 1'b0;
        timer_clear   = 1'b0;
        timer_en      = 1'b0;

        case (state_q)
            IDLE: begin
                pselx_d   = 1'b0;
                penable_d = 1'b0;
                if (cmd_valid) begin
                    pwrite_d    = cmd_write;
                    paddr_d     = cmd_addr;
                    pwdata_d    = cmd_wdata;
                    pselx_d     = 1'b1;
                    timer_clear = 1'b1;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    pselx_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    state_d     = IDLE;
                end else begin
                    timer_en = 1'b1;
                    // Completion with pready takes priority, so expiry is only checked here.
                    if (timer_expired) begin
                        pselx_d       = 1'b0;
                        penable_d     = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_err_d     = 1'b1;
                        rsp_timeout_d = 1'b1;
                        rsp_rdata_d   = '0;
                        state_d       = IDLE;
                    end
                end
            end
            default: begin
                pselx_d   = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            pselx_q       <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pselx_q       <= pselx_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // Ready depends only on state, gated low while reset is held.
    assign cmd_ready   = presetn && (state_q == IDLE);
    assign pselx       = pselx_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: single transfers, wait states, slave error,
// timeout abort, back-to-back commands and asynchronous reset mid-transfer.
module tb_apb_master;
    import apb_pkg::*;

    localparam int TO = 16;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pslverr = 1'b0;

    int checks = 0;
    int errors = 0;

    apb_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO)
    ) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .pselx       (pselx),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic check_bus_zero(input string tag);
        check({tag, "_psel"},  pselx,       1'b0);
        check({tag, "_pen"},   penable,     1'b0);
        check({tag, "_pwr"},   pwrite,      1'b0);
        check({tag, "_paddr"}, paddr,       32'h0);
        check({tag, "_pwd"},   pwdata,      32'h0);
        check({tag, "_rv"},    rsp_valid,   1'b0);
        check({tag, "_rd"},    rsp_rdata,   32'h0);
        check({tag, "_rerr"},  rsp_err,     1'b0);
        check({tag, "_rto"},   rsp_timeout, 1'b0);
        check({tag, "_rdy"},   cmd_ready,   1'b0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the response cycle.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd, input int waits, input logic to_exp,
                        input logic keep_valid);
        logic        err;
        int          edges;
        logic [31:0] exp_rd;
        err    = (addr >= APB_ADDR_LIMIT) && !to_exp;
        edges  = to_exp ? TO : waits + 1;
        exp_rd = (to_exp || wr) ? 32'h0 : rd;

        check("idle_rdy", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        pready = 1'b0; pslverr = 1'b0;
        tick;
        cmd_valid = keep_valid;
        check("setup_psel",  pselx,     1'b1);
        check("setup_pen",   penable,   1'b0);
        check("setup_rdy",   cmd_ready, 1'b0);
        check("setup_paddr", paddr,     addr);
        check("setup_pwr",   pwrite,    wr);
        check("setup_pwd",   pwdata,    wdata);
        tick;
        for (int i = 0; i < edges; i++) begin
            check("acc_psel",  pselx,     1'b1);
            check("acc_pen",   penable,   1'b1);
            check("acc_paddr", paddr,     addr);
            check("acc_pwd",   pwdata,    wdata);
            check("acc_rv",    rsp_valid, 1'b0);
            check("acc_rdy",   cmd_ready, 1'b0);
            pready  = !to_exp && (i == edges - 1);
            prdata  = pready ? rd : 32'h0BAD_0BAD;
            pslverr = pready ? err : 1'b1;
            tick;
        end
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        $display("xfer wr=%0d addr=%0h wdata=%0h -> rv=%0d rdata=%0h err=%0d to=%0d",
                 wr, addr, wdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
        check("rsp_valid", rsp_valid,   1'b1);
        check("rsp_err",   rsp_err,     err || to_exp);
        check("rsp_to",    rsp_timeout, to_exp);
        check("rsp_rdata", rsp_rdata,   exp_rd);
        check("rsp_psel",  pselx,       1'b0);
        check("rsp_pen",   penable,     1'b0);
        check("rsp_rdy",   cmd_ready,   1'b1);
    endtask

    task automatic idle_cycle(input logic [31:0] hold_rd);
        tick;
        check("idle_rv",   rsp_valid,   1'b0);
        check("idle_err",  rsp_err,     1'b0);
        check("idle_to",   rsp_timeout, 1'b0);
        check("idle_psel", pselx,       1'b0);
        check("idle_rd",   rsp_rdata,   hold_rd);
    endtask

    initial begin
        #1;
        check_bus_zero("rst");
        repeat (2) @(negedge pclk);
        presetn = 1'b1;
        tick;

        xfer(1'b1, 32'd2, 32'hDEADBEEF, 32'h0, 0, 1'b0, 1'b0);
        idle_cycle(32'h0);

        xfer(1'b0, 32'd2, 32'h0, 32'hDEADBEEF, 3, 1'b0, 1'b0);
        idle_cycle(32'hDEADBEEF);

        xfer(1'b0, 32'h800, 32'h0, 32'h55AA0011, 0, 1'b0, 1'b0);
        idle_cycle(32'h55AA0011);

        xfer(1'b0, 32'h10, 32'h0, 32'h0, 0, 1'b1, 1'b0);
        idle_cycle(32'h0);
        xfer(1'b1, 32'h4, 32'hCAFEF00D, 32'h0, 0, 1'b0, 1'b0);
        idle_cycle(32'h0);

        for (int i = 0; i < 3; i++) begin
            xfer(1'b1, i, 32'h100 + i, 32'h0, 0, 1'b0, 1'b1);
        end
        cmd_valid = 1'b0;
        idle_cycle(32'h0);
        idle_cycle(32'h0);

        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h3; cmd_wdata = 32'h77;
        tick;
        cmd_valid = 1'b0;
        tick;
        check("pre_rst_psel", pselx, 1'b1);
        #2 presetn = 1'b0;
        #1;
        check_bus_zero("mid_rst");
        repeat (2) begin
            tick;
            check("rst_hold_rv",   rsp_valid, 1'b0);
            check("rst_hold_psel", pselx,     1'b0);
        end
        presetn = 1'b1;
        tick;
        check("post_rst_rv", rsp_valid, 1'b0);
        xfer(1'b0, 32'h0, 32'h0, 32'h12345678, 1, 1'b0, 1'b0);
        idle_cycle(32'h12345678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester stage that sits directly upstream of the APB peripheral and drives its pselx/penable/paddr/pwrite/pwdata bus.
- Converts a simple valid/ready command interface from the system controller or testbench sequencer into compliant APB SETUP/ACCESS transfers.
- Returns read data and error status on a one-cycle response strobe.
- Adds a wait-state timeout so a hung slave cannot stall the system.

Parameters:
- ADDR_W, 32, paddr/cmd_addr width
- DATA_W, 32, pwdata/prdata width
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
- pclk  in  1  APB clock, all logic on rising edge
- presetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  transfer address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion strobe
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_err  out  1  slave error or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- pselx  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pready  in  1  slave ready
- prdata  in  DATA_W  slave read data
- pslverr  in  1  slave error

Behaviour:
- Reset: presetn is asynchronous and active-low. While presetn=0, state=IDLE and every output is 0: pselx, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout. cmd_ready is also 0 during reset. All outputs except cmd_ready are registered.
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1 (combinational from state).
  - On an edge with cmd_valid=1, capture cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata, set pselx=1, and go to SETUP.
  - paddr/pwdata/pwrite hold their last values while idle.
- SETUP (exactly one cycle): pselx=1, penable=0. Next edge: penable=1, go to ACCESS.
- ACCESS:
  - pselx=1, penable=1; paddr/pwrite/pwdata stable.
  - On an edge with pready=1:
    - pselx=0, penable=0.
    - rsp_valid=1 for exactly one cycle.
    - rsp_err=pslverr, rsp_timeout=0.
    - rsp_rdata=prdata for reads, 0 for writes.
    - Go to IDLE.
  - pslverr and prdata are sampled only on this edge.
  - A wait counter increments on each ACCESS edge with pready=0. It clears on entry to SETUP.
  - If TIMEOUT>0 and the counter reaches TIMEOUT without pready: pselx=0, penable=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to IDLE.
  - If pready=1 on the same edge the counter would reach TIMEOUT, the normal completion wins.
- rsp_valid, rsp_err and rsp_timeout are 0 in every cycle except the completion cycle. rsp_rdata holds its value until the next completion.
- Latency: command accepted at edge N; SETUP in cycle N..N+1; first ACCESS cycle N+1..N+2. Zero-wait completion sampled at edge N+2, so rsp_valid and cmd_ready=1 are both high in cycle N+2. Minimum is 3 cycles per transfer; each wait state adds 1.
- cmd_valid while not in IDLE is ignored (cmd_ready=0). The requester holds cmd_valid and the command fields stable until accepted.
- Back-to-back commands: the next command is accepted in the IDLE cycle that coincides with rsp_valid. No combinational path from pready to cmd_ready.
- Reset mid-transfer: outputs clear immediately. The in-flight transfer is dropped with no rsp_valid. The first command after reset release behaves normally.
- Unused encoding / illegal state: recover to IDLE with all strobes 0.

Decomposition:
- Shared package apb_pkg:
  - apb_state_e enum {IDLE, SETUP, ACCESS}
  - default ADDR_W/DATA_W constants
  - the peripheral's legal address limit constant (1024), shared by the slave and the benches
- One sub-module, apb_wait_timer:
  - ceil(log2(TIMEOUT+1))-bit counter
  - inputs: clear, count_en
  - output: expired
  - asynchronously reset by presetn
- FSM and datapath registers stay in apb_master.

Test Plan:
- Write addr 2, data 0xDEADBEEF, pready tied 1 -> pselx high 2 cycles, penable high 1 cycle, pwdata=0xDEADBEEF throughout, rsp_valid 1 cycle, rsp_err=0, rsp_rdata=0.
- Read addr 2, slave inserts 3 wait states then returns prdata=0xDEADBEEF -> penable high 4 cycles, paddr stable at 2, rsp_rdata=0xDEADBEEF, rsp_err=0, total 6 cycles accept-to-rsp.
- Read addr 0x800, slave returns pready=1 with pslverr=1 -> rsp_err=1, rsp_timeout=0, pselx/penable drop the next cycle.
- TIMEOUT=16, pready held 0 -> exactly 16 ACCESS edges, then rsp_valid=1, rsp_err=1, rsp_timeout=1, pselx=0; a following write completes normally.
- presetn pulled low asynchronously mid-ACCESS -> pselx/penable/paddr/pwdata go 0 before the next pclk edge, no rsp_valid; after release a read of addr 0 completes.
- cmd_valid held high for writes to addr 0,1,2 with pready=1 -> three transfers at a 3-cycle cadence, cmd_ready high on cycles 0, 3, 6, three rsp_valid pulses, no command lost or duplicated.
